// File: rtl/cmsdk_uart_stimulus.sv
// Bench-side UART transmitter: queues bytes in a small FIFO and serialises
// them as 8-bit async frames onto TXD for an MCU receive pin.
module cmsdk_uart_stimulus #(
  parameter int BAUD_DIV  = 16,
  parameter int FIFO_AW   = 2,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [7:0]         WDATA,
  input  logic               WVALID,
  output logic               WREADY,
  output logic               TXD,
  output logic               BUSY,
  output logic               TX_DONE,
  output logic [FIFO_AW:0]   LEVEL
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SLEN  = STOP_BITS * BAUD_DIV;
  localparam int CW    = $clog2(SLEN + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [2:0]        idx, idx_n;
  logic [7:0]        data, data_n;
  logic [7:0]        mem [DEPTH];
  logic [FIFO_AW:0]  wptr, rptr, level_n;
  logic              push, pop, bit_end;
  logic              txd_n, done_n;

  assign push    = WVALID & WREADY;
  assign level_n = LEVEL + (FIFO_AW+1)'(push)
                         - (FIFO_AW+1)'(pop);

  // the stop phase is one long "bit" covering all stop bits
  always_comb begin
    if (state == STOP)
      bit_end = (cnt == CW'(SLEN - 1));
    else
      bit_end = (cnt == CW'(BAUD_DIV - 1));
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    data_n  = data;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (LEVEL != '0) begin
          pop     = 1'b1;
          data_n  = mem[rptr[FIFO_AW-1:0]];
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_n   = '0;
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_n = '0;
          idx_n = idx + 3'd1;
          if (idx == 3'd7)
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          cnt_n   = '0;
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_n = '0;
          if (LEVEL != '0) begin
            pop     = 1'b1;
            data_n  = mem[rptr[FIFO_AW-1:0]];
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    unique case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = data_n[idx_n];
      PARITY:  txd_n = ^data_n;
      default: txd_n = 1'b1;
    endcase
    done_n = (state_n == STOP) && (cnt_n == CW'(SLEN - 1));
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      data    <= '0;
      wptr    <= '0;
      rptr    <= '0;
      LEVEL   <= '0;
      WREADY  <= 1'b1;
      BUSY    <= 1'b0;
      TXD     <= 1'b1;
      TX_DONE <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      data    <= data_n;
      wptr    <= wptr + (FIFO_AW+1)'(push);
      rptr    <= rptr + (FIFO_AW+1)'(pop);
      LEVEL   <= level_n;
      WREADY  <= (level_n != (FIFO_AW+1)'(DEPTH));
      BUSY    <= (state_n != IDLE) || (level_n != '0);
      TXD     <= txd_n;
      TX_DONE <= done_n;
    end
  end

  always_ff @(posedge CLK) begin
    if (push)
      mem[wptr[FIFO_AW-1:0]] <= WDATA;
  end

endmodule

// File: doc/cmsdk_uart_stimulus.md
Name: cmsdk_uart_stimulus

Overview:
Testbench-side UART transmitter that drives serial characters into an MCU UART RXD pin. It is the input-direction counterpart to the UART capture device. Bench code or a script queues bytes through a valid/ready write port into a small FIFO. The block serialises them as 8-bit async frames (optional even parity, 1 or 2 stop bits) at a fixed clocks-per-bit rate, so firmware receive paths and the UART command/escape protocol can be exercised.

Parameters:
BAUD_DIV, 16, clock cycles per serial bit; legal range is 2 or greater.
FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries.
PARITY_EN, 0, 1 inserts an even parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
CLK  input  1  clock (same clock as the MCU XTAL1/PCLK)
RESET  input  1  asynchronous, active-high reset
WDATA  input  8  byte to queue
WVALID  input  1  write request
WREADY  output  1  FIFO can accept; equals not-full
TXD  output  1  serial output, idle high; connect to the MCU UART RXD pin
BUSY  output  1  high when FIFO is non-empty or a frame is in progress
TX_DONE  output  1  one-cycle pulse at the end of each frame's final stop bit
LEVEL  output  FIFO_AW+1  current FIFO occupancy

Behaviour:
- Reset (async, active-high): TXD=1, WREADY=1, BUSY=0, TX_DONE=0, LEVEL=0. FIFO pointers cleared, state=IDLE, baud counter=0.
- Reset asserted mid-frame aborts the frame immediately; queued bytes are discarded.
- Write handshake: a push occurs at a CLK edge when WVALID and WREADY are both high. WDATA is sampled at that edge. WVALID while full is ignored (no push, no overwrite); the bench must hold it.
- A push and a pop in the same cycle leave LEVEL unchanged. A push when full is blocked even if a pop occurs in the same cycle, because WREADY is registered-full based.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TXD=1. If LEVEL!=0 at a clock edge: pop the head into the shift register, enter START, TXD=0 from that edge.
  - START: TXD=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
  - DATA: TXD=shift[0] (LSB first), BAUD_DIV cycles per bit, 8 bits. Then go to PARITY if PARITY_EN, else STOP.
  - PARITY: TXD = XOR of the 8 data bits (even parity) for BAUD_DIV cycles.
  - STOP: TXD=1 for STOP_BITS*BAUD_DIV cycles. On the last cycle TX_DONE=1. At that edge, if LEVEL!=0, pop and enter START directly (zero idle gap); else go to IDLE.
- Baud counter counts 0..BAUD_DIV-1 and reloads on each bit boundary. Every bit period is exactly BAUD_DIV cycles.
- Frame length = (10 + PARITY_EN + STOP_BITS - 1) * BAUD_DIV cycles.
- Latency: a byte written at edge N into an empty FIFO with state IDLE drives TXD low from edge N+1.
- FIFO pointers are FIFO_AW+1 bits wide with natural wrap. Full = MSBs differ and lower bits equal. Empty = pointers equal. LEVEL = wptr - rptr, modulo 2**(FIFO_AW+1).
- All outputs are registered; TXD has no combinational path from WVALID.
- BUSY = (state!=IDLE) | (LEVEL!=0).

Test Plan:
- BAUD_DIV=4, defaults. Write 0x55 at edge N -> TXD 0 for cycles N+1..N+4, then 1,0,1,0,1,0,1,0 at 4 cycles each, then 1 for 4 cycles. TX_DONE pulses at cycle N+40, then BUSY=0.
- Write 0x41 then 0x42 on consecutive cycles -> the second start bit immediately follows the first stop bit with no gap. 80 cycles total, two TX_DONE pulses 40 cycles apart.
- FIFO_AW=2, TX idle, WVALID held with 6 bytes on consecutive cycles -> the first 5 are accepted (one popped at edge 2), WREADY=0 and LEVEL=4 on the 6th. The 6th is accepted in the cycle after the first frame's TX_DONE pop. All 6 bytes are emitted in order.
- PARITY_EN=1, STOP_BITS=2, BAUD_DIV=4, byte 0x07 -> parity bit 1, then TXD high for 8 cycles. 48-cycle frame.
- Assert RESET during data bit 3 of 0x00 with 2 bytes queued -> TXD=1 asynchronously, LEVEL=0, BUSY=0. No further frames after release.
- Capture loopback: drive TXD into cmsdk_uart_capture at a matching rate, send the string "OK\n" -> the capture prints "OK".
